// File: rtl/mcu_sys_pkg.sv
// -----------------------------------------------------------------------------
// mcu_sys_pkg
// Shared definitions for the system-control command target: command codes,
// FSM state type, fixed ID reply byte and config bank geometry.
// Optional feature macro used by the design: SYS_TARGET_CFG_READBACK_EN
// -----------------------------------------------------------------------------
package mcu_sys_pkg;

   localparam logic [7:0] CMD_ID      = 8'h00;
   localparam logic [7:0] CMD_SET_CFG = 8'h01;
   localparam logic [7:0] CMD_GET_CFG = 8'h02;
   localparam logic [7:0] CMD_RESET   = 8'h03;
   localparam logic [7:0] CMD_STATUS  = 8'h04;

   // Second byte of the ID reply sequence
   localparam logic [7:0] ID_MAGIC    = 8'h42;

   localparam int unsigned CFG_REGS   = 8;

   // Reply returned for an out-of-range read index
   localparam logic [7:0] CFG_BAD_IDX = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARG0  = 2'd1,
      ST_ARG1  = 2'd2,
      ST_DRAIN = 2'd3
   } state_e;

   // True when a register index addresses an existing config register
   function automatic logic idx_in_range(input logic [7:0] idx);
      return (idx < 8'(CFG_REGS));
   endfunction

endpackage

// File: rtl/mcu_sys_target_if.sv
// -----------------------------------------------------------------------------
// mcu_sys_target_if
// Byte-strobe link between the MCU SPI byte interface (master) and the
// system-control target (slave).
//   mcu_sys_strobe : one-cycle pulse, mcu_dout holds a byte for this target
//   mcu_start      : high while the transfer's first payload byte is present
//   mcu_dout       : byte from the MCU
//   mcu_sys_din    : reply byte toward the MCU
// -----------------------------------------------------------------------------
interface mcu_sys_target_if;

   logic       mcu_sys_strobe;
   logic       mcu_start;
   logic [7:0] mcu_dout;
   logic [7:0] mcu_sys_din;

   modport master (
      output mcu_sys_strobe,
      output mcu_start,
      output mcu_dout,
      input  mcu_sys_din
   );

   modport slave (
      input  mcu_sys_strobe,
      input  mcu_start,
      input  mcu_dout,
      output mcu_sys_din
   );

endinterface

// File: rtl/mcu_sys_cfgbank.sv
// -----------------------------------------------------------------------------
// mcu_sys_cfgbank
// Bank of eight 8-bit configuration registers, async reset to CFG_RESET.
// Ports:
//   clk, reset_n          : clock, async active-low reset
//   we_i, wr_idx_i, wr_val_i : write port (index already range-checked)
//   rd_idx_i -> rd_val_o  : read port, 8'hFF for idx >= 8
//   cfg_o                 : whole bank, register i at bits 8i+7:8i
// Macro SYS_TARGET_CFG_READBACK_EN: when undefined the read mux is not built
// and rd_val_o is constant 8'h00.
// -----------------------------------------------------------------------------
module mcu_sys_cfgbank
   import mcu_sys_pkg::*;
#(
   parameter logic [63:0] CFG_RESET = 64'h0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        we_i,
   input  logic [2:0]  wr_idx_i,
   input  logic [7:0]  wr_val_i,
   input  logic [7:0]  rd_idx_i,
   output logic [7:0]  rd_val_o,
   output logic [63:0] cfg_o
);

   logic [63:0] regs_q;

   // Register bank storage with single byte-wide write port
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         regs_q <= CFG_RESET;
      end else if (we_i) begin
         regs_q[{wr_idx_i, 3'b000} +: 8] <= wr_val_i;
      end else begin
         regs_q <= regs_q;
      end
   end

   assign cfg_o = regs_q;

`ifdef SYS_TARGET_CFG_READBACK_EN
   // Read-back mux with out-of-range marker
   always_comb begin
      rd_val_o = CFG_BAD_IDX;
      if (idx_in_range(rd_idx_i)) begin
         rd_val_o = regs_q[{rd_idx_i[2:0], 3'b000} +: 8];
      end else begin
         rd_val_o = CFG_BAD_IDX;
      end
   end
`else
   logic unused_rd_idx_s;
   assign unused_rd_idx_s = ^rd_idx_i;
   assign rd_val_o        = 8'h00;
`endif

endmodule

// File: rtl/mcu_sys_target.sv
// -----------------------------------------------------------------------------
// mcu_sys_target
// System-control command target downstream of the MCU SPI byte interface.
// Decodes ID / SET_CFG / GET_CFG / RESET / STATUS, owns the config bank and
// the core reset request, and presents the reply byte for the next SPI byte.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : mcu_sys_strobe, mcu_start, mcu_dout in; mcu_sys_din out
//   cfg          : config bank, register i at bits 8i+7:8i
//   cfg_wr       : one-cycle pulse after a config register write
//   sys_reset    : core reset request, active high, set out of reset
//   status       : core status, captured on the STATUS command byte
// Macro SYS_TARGET_CFG_READBACK_EN enables GET_CFG read-back; otherwise
// GET_CFG consumes its index and replies 8'h00.
// -----------------------------------------------------------------------------
module mcu_sys_target
   import mcu_sys_pkg::*;
#(
   parameter logic [7:0]  CORE_ID   = 8'h5C,
   parameter logic [7:0]  CORE_VER  = 8'h01,
   parameter logic [63:0] CFG_RESET = 64'h0
) (
   input  logic             clk,
   input  logic             reset_n,
   mcu_sys_target_if.slave  bus,
   output logic [63:0]      cfg,
   output logic             cfg_wr,
   output logic             sys_reset,
   input  logic [7:0]       status
);

   state_e      state_q,     state_d;
   logic [7:0]  cmd_q,       cmd_d;
   logic [7:0]  idx_q,       idx_d;
   logic [1:0]  cnt_q,       cnt_d;      // argument bytes seen, saturating
   logic [7:0]  din_q,       din_d;
   logic        cfg_wr_q,    cfg_wr_d;
   logic        sys_reset_q, sys_reset_d;

   logic        is_cmd_s;
   logic        is_arg_s;
   logic        we_s;
   logic [7:0]  rd_val_s;

   assign is_cmd_s = bus.mcu_sys_strobe &  bus.mcu_start;
   assign is_arg_s = bus.mcu_sys_strobe & ~bus.mcu_start;

   mcu_sys_cfgbank #(
      .CFG_RESET (CFG_RESET)
   ) u_cfgbank (
      .clk      (clk),
      .reset_n  (reset_n),
      .we_i     (we_s),
      .wr_idx_i (idx_q[2:0]),
      .wr_val_i (bus.mcu_dout),
      .rd_idx_i (bus.mcu_dout),
      .rd_val_o (rd_val_s),
      .cfg_o    (cfg)
   );

   // State and reply registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         cmd_q       <= 8'h00;
         idx_q       <= 8'h00;
         cnt_q       <= 2'd0;
         din_q       <= 8'h00;
         cfg_wr_q    <= 1'b0;
         sys_reset_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         din_q       <= din_d;
         cfg_wr_q    <= cfg_wr_d;
         sys_reset_q <= sys_reset_d;
      end
   end

   // Command parser: next state, bank write and the reply for the next byte
   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      din_d       = din_q;
      cfg_wr_d    = 1'b0;
      sys_reset_d = sys_reset_q;
      we_s        = 1'b0;

      if (is_cmd_s) begin
         // A command byte restarts parsing from any state
         cmd_d = bus.mcu_dout;
         cnt_d = 2'd0;
         case (bus.mcu_dout)
            CMD_ID: begin
               state_d = ST_ARG0;
               din_d   = CORE_ID;
            end
            CMD_SET_CFG, CMD_GET_CFG, CMD_RESET: begin
               state_d = ST_ARG0;
               din_d   = 8'h00;
            end
            CMD_STATUS: begin
               state_d = ST_ARG0;
               din_d   = status;
            end
            default: begin
               state_d = ST_DRAIN;
               din_d   = 8'h00;
            end
         endcase
      end else if (is_arg_s) begin
         cnt_d = (cnt_q == 2'd3) ? cnt_q : (cnt_q + 2'd1);
         case (state_q)
            ST_IDLE: begin
               // Stray argument with no command in flight: ignored entirely
               cnt_d = cnt_q;
            end
            ST_ARG0: begin
               din_d   = 8'h00;
               state_d = ST_DRAIN;
               case (cmd_q)
                  CMD_ID: begin
                     din_d = ID_MAGIC;
                  end
                  CMD_SET_CFG: begin
                     idx_d   = bus.mcu_dout;
                     state_d = ST_ARG1;
                  end
                  CMD_GET_CFG: begin
                     din_d = rd_val_s;
                  end
                  CMD_RESET: begin
                     sys_reset_d = bus.mcu_dout[0];
                  end
                  default: begin
                     din_d = 8'h00;
                  end
               endcase
            end
            ST_ARG1: begin
               // Only SET_CFG reaches here; out-of-range index is dropped
               din_d   = 8'h00;
               state_d = ST_DRAIN;
               if (idx_in_range(idx_q)) begin
                  we_s     = 1'b1;
                  cfg_wr_d = 1'b1;
               end else begin
                  we_s     = 1'b0;
                  cfg_wr_d = 1'b0;
               end
            end
            ST_DRAIN: begin
               // Third ID reply byte is the version; everything else is zero
               if ((cmd_q == CMD_ID) && (cnt_q == 2'd1)) begin
                  din_d = CORE_VER;
               end else begin
                  din_d = 8'h00;
               end
            end
            default: begin
               state_d = ST_IDLE;
               din_d   = 8'h00;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   assign bus.mcu_sys_din = din_q;
   assign cfg_wr          = cfg_wr_q;
   assign sys_reset       = sys_reset_q;

endmodule

// File: tb/tb_mcu_sys_target.sv
// -----------------------------------------------------------------------------
// tb_mcu_sys_target
// Directed stimulus for mcu_sys_target. Each strobe pushes the expected reply
// byte into a queue; a monitor pops and compares one clk after every strobe.
// -----------------------------------------------------------------------------
module tb_mcu_sys_target;

   logic        clk;
   logic        reset_n;
   logic [63:0] cfg;
   logic        cfg_wr;
   logic        sys_reset;
   logic [7:0]  status;

   int          checks;
   int          failures;
   logic [7:0]  exp_q [$];
   logic [63:0] exp_cfg;
   logic        wr1, wr2, sr1;

   mcu_sys_target_if bus ();

   mcu_sys_target #(
      .CORE_ID   (8'h5C),
      .CORE_VER  (8'h01),
      .CFG_RESET (64'h0)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .bus       (bus),
      .cfg       (cfg),
      .cfg_wr    (cfg_wr),
      .sys_reset (sys_reset),
      .status    (status)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Monitor: one clk after each strobe the reply byte must match the queue head
   initial begin
      forever begin
         @(posedge clk);
         if (bus.mcu_sys_strobe === 1'b1) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL reply_unexpected actual=%h expected=none", bus.mcu_sys_din);
            end else begin
               check("reply_byte", {56'h0, bus.mcu_sys_din}, {56'h0, exp_q.pop_front()});
            end
         end
      end
   end

   // Issue one byte strobe and capture cfg_wr / sys_reset in the two cycles after
   task automatic send(input logic st, input logic [7:0] b, input logic [7:0] exp_din,
                       output logic w1, output logic w2, output logic s1);
      @(negedge clk);
      bus.mcu_sys_strobe = 1'b1;
      bus.mcu_start      = st;
      bus.mcu_dout       = b;
      exp_q.push_back(exp_din);
      @(negedge clk);
      w1 = cfg_wr;
      s1 = sys_reset;
      bus.mcu_sys_strobe = 1'b0;
      bus.mcu_start      = 1'b0;
      bus.mcu_dout       = 8'h00;
      @(negedge clk);
      w2 = cfg_wr;
      repeat (7) @(negedge clk);
   endtask

   logic [7:0] exp_get3, exp_get9;

   initial begin
      checks   = 0;
      failures = 0;
      reset_n  = 1'b0;
      status   = 8'h00;
      bus.mcu_sys_strobe = 1'b0;
      bus.mcu_start      = 1'b0;
      bus.mcu_dout       = 8'h00;
`ifdef SYS_TARGET_CFG_READBACK_EN
      exp_get3 = 8'hA5;
      exp_get9 = 8'hFF;
`else
      exp_get3 = 8'h00;
      exp_get9 = 8'h00;
`endif
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // Reset state
      exp_cfg = 64'h0;
      check("rst_cfg",       cfg,                 exp_cfg);
      check("rst_sys_reset", {63'h0, sys_reset},  64'h1);
      check("rst_din",       {56'h0, bus.mcu_sys_din}, 64'h0);
      check("rst_cfg_wr",    {63'h0, cfg_wr},     64'h0);

      // ID sequence
      send(1'b1, 8'h00, 8'h5C, wr1, wr2, sr1);
      send(1'b0, 8'hAA, 8'h42, wr1, wr2, sr1);
      send(1'b0, 8'hBB, 8'h01, wr1, wr2, sr1);
      send(1'b0, 8'hCC, 8'h00, wr1, wr2, sr1);

      // SET_CFG 3, A5
      send(1'b1, 8'h01, 8'h00, wr1, wr2, sr1);
      send(1'b0, 8'h03, 8'h00, wr1, wr2, sr1);
      check("setcfg_idx_no_wr", {63'h0, wr1}, 64'h0);
      send(1'b0, 8'hA5, 8'h00, wr1, wr2, sr1);
      exp_cfg = 64'h00000000_A5000000;
      check("setcfg3_wr_pulse", {63'h0, wr1}, 64'h1);
      check("setcfg3_wr_end",   {63'h0, wr2}, 64'h0);
      check("setcfg3_cfg",      cfg,          exp_cfg);

      // GET_CFG 3 then an extra argument
      send(1'b1, 8'h02, 8'h00,    wr1, wr2, sr1);
      send(1'b0, 8'h03, exp_get3, wr1, wr2, sr1);
      send(1'b0, 8'h03, 8'h00,    wr1, wr2, sr1);

      // SET_CFG 9, 11: dropped
      send(1'b1, 8'h01, 8'h00, wr1, wr2, sr1);
      send(1'b0, 8'h09, 8'h00, wr1, wr2, sr1);
      send(1'b0, 8'h11, 8'h00, wr1, wr2, sr1);
      check("setcfg9_no_wr", {63'h0, wr1}, 64'h0);
      check("setcfg9_cfg",   cfg,          exp_cfg);

      // SET_CFG 7, 3C: top register boundary
      send(1'b1, 8'h01, 8'h00, wr1, wr2, sr1);
      send(1'b0, 8'h07, 8'h00, wr1, wr2, sr1);
      send(1'b0, 8'h3C, 8'h00, wr1, wr2, sr1);
      exp_cfg = 64'h3C000000_A5000000;
      check("setcfg7_wr_pulse", {63'h0, wr1}, 64'h1);
      check("setcfg7_cfg",      cfg,          exp_cfg);

      // GET_CFG 9: out of range
      send(1'b1, 8'h02, 8'h00,    wr1, wr2, sr1);
      send(1'b0, 8'h09, exp_get9, wr1, wr2, sr1);

      // RESET 0 then RESET 1
      send(1'b1, 8'h03, 8'h00, wr1, wr2, sr1);
      send(1'b0, 8'h00, 8'h00, wr1, wr2, sr1);
      check("reset0_sys_reset", {63'h0, sr1}, 64'h0);
      send(1'b1, 8'h03, 8'h00, wr1, wr2, sr1);
      send(1'b0, 8'h01, 8'h00, wr1, wr2, sr1);
      check("reset1_sys_reset", {63'h0, sr1}, 64'h1);

      // SET_CFG 2 interrupted by STATUS
      status = 8'h3C;
      send(1'b1, 8'h01, 8'h00, wr1, wr2, sr1);
      send(1'b0, 8'h02, 8'h00, wr1, wr2, sr1);
      send(1'b1, 8'h04, 8'h3C, wr1, wr2, sr1);
      status = 8'h99;
      send(1'b0, 8'h55, 8'h00, wr1, wr2, sr1);
      check("abort_no_wr", {63'h0, wr1}, 64'h0);
      check("abort_cfg",   cfg,          exp_cfg);

      // Unknown command
      send(1'b1, 8'h55, 8'h00, wr1, wr2, sr1);
      send(1'b0, 8'h01, 8'h00, wr1, wr2, sr1);

      // Drop sys_reset, then async reset mid SET_CFG after idx
      send(1'b1, 8'h03, 8'h00, wr1, wr2, sr1);
      send(1'b0, 8'h00, 8'h00, wr1, wr2, sr1);
      send(1'b1, 8'h01, 8'h00, wr1, wr2, sr1);
      send(1'b0, 8'h05, 8'h00, wr1, wr2, sr1);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      exp_cfg = 64'h0;
      check("arst_cfg",       cfg,                 exp_cfg);
      check("arst_sys_reset", {63'h0, sys_reset},  64'h1);
      check("arst_din",       {56'h0, bus.mcu_sys_din}, 64'h0);
      check("arst_cfg_wr",    {63'h0, cfg_wr},     64'h0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // Stray argument after reset must do nothing
      send(1'b0, 8'h77, 8'h00, wr1, wr2, sr1);
      check("stray_no_wr",     {63'h0, wr1}, 64'h0);
      check("stray_cfg",       cfg,          exp_cfg);
      check("stray_sys_reset", {63'h0, sr1}, 64'h1);

      // Bounded drain of the scoreboard
      for (int i = 0; i < 50; i++) begin
         if (exp_q.size() != 0) @(negedge clk);
      end
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
